// File: rtl/dram_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module : dram_arbiter_pkg
// Brief  : Shared state encodings and sizing helpers for the DRAM port arbiter.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package dram_arbiter_pkg;

    typedef logic [1:0] arb_state_t;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_OWN0 = 2'd1;
    localparam logic [1:0] ARB_OWN1 = 2'd2;

    localparam int DEF_MAX_BURST = 8;

    // Keeps the burst counter at least one bit wide when MAX_BURST is 1.
    function automatic int cnt_width(input int max_burst);
        return (max_burst > 1) ? $clog2(max_burst) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dram_arbiter_if.sv
//------------------------------------------------------------------------------
// Module : dram_arbiter_if
// Brief  : One requester's transfer handshake towards the DRAM arbiter.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface dram_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

`default_nettype wire

// File: rtl/arb_rr_pick.sv
//------------------------------------------------------------------------------
// Module : arb_rr_pick
// Brief  : Two-way round-robin pick; on a tie the master not served last wins.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module arb_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic pick,
    output logic valid
);
    assign valid = req0 | req1;
    assign pick  = (req0 & req1) ? ~last : req1;
endmodule

`default_nettype wire

// File: rtl/dram_arbiter.sv
//------------------------------------------------------------------------------
// Module : dram_arbiter
// Brief  : Round-robin, burst-bounded sharing of one DRAM port by two masters.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dram_arbiter
    import dram_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic              clk,
    input  logic              rst_n,
    dram_arbiter_if.slave     m0,
    dram_arbiter_if.slave     m1,
    output logic [ADDR_W-1:0] dram_addr,
    output logic              dram_we,
    output logic [DATA_W-1:0] dram_wdata,
    input  logic [DATA_W-1:0] dram_rd
);
    localparam int               CNT_W      = cnt_width(MAX_BURST);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_t        r_state, w_state_nxt;
    logic              r_last, w_last_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_rvalid0, r_rvalid1;
    logic [DATA_W-1:0] r_rdata0, r_rdata1;

    logic w_own0, w_own1, w_acc0, w_acc1, w_acc_own, w_own_req, w_cnt_end;
    logic w_pick, w_pick_valid;

    assign w_own0    = (r_state == ARB_OWN0);
    assign w_own1    = (r_state == ARB_OWN1);
    assign w_acc0    = m0.req & w_own0;
    assign w_acc1    = m1.req & w_own1;
    assign w_acc_own = w_acc0 | w_acc1;
    assign w_own_req = w_own0 ? m0.req : m1.req;
    assign w_cnt_end = w_acc_own & (r_cnt == C_CNT_LAST);

    // r_last always names the current owner while one is granted, so the same
    // tie-break serves both the idle decision and the end-of-burst handover.
    arb_rr_pick u_pick (
        .req0  (m0.req),
        .req1  (m1.req),
        .last  (r_last),
        .pick  (w_pick),
        .valid (w_pick_valid)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = w_pick ? ARB_OWN1 : ARB_OWN0;
                    w_last_nxt  = w_pick;
                    w_cnt_nxt   = '0;
                end
            end
            ARB_OWN0, ARB_OWN1: begin
                if (!w_own_req || w_cnt_end) begin
                    w_cnt_nxt = '0;
                    if (w_pick_valid) begin
                        w_state_nxt = w_pick ? ARB_OWN1 : ARB_OWN0;
                        w_last_nxt  = w_pick;
                    end else begin
                        w_state_nxt = ARB_IDLE;
                    end
                end else if (w_acc_own) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ARB_IDLE;
            r_last    <= 1'b1;
            r_cnt     <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_last    <= w_last_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rvalid0 <= w_acc0 & ~m0.we;
            r_rvalid1 <= w_acc1 & ~m1.we;
            if (w_acc0 & ~m0.we) r_rdata0 <= dram_rd;
            if (w_acc1 & ~m1.we) r_rdata1 <= dram_rd;
        end
    end

    assign m0.gnt    = w_own0;
    assign m1.gnt    = w_own1;
    assign m0.rvalid = r_rvalid0;
    assign m1.rvalid = r_rvalid1;
    assign m0.rdata  = r_rdata0;
    assign m1.rdata  = r_rdata1;

    // Write enable is qualified by acceptance so an idle or reset port never writes.
    always_comb begin
        dram_addr  = '0;
        dram_wdata = '0;
        dram_we    = 1'b0;
        if (w_own0) begin
            dram_addr  = m0.addr;
            dram_wdata = m0.wdata;
            dram_we    = w_acc0 & m0.we;
        end else if (w_own1) begin
            dram_addr  = m1.addr;
            dram_wdata = m1.wdata;
            dram_we    = w_acc1 & m1.we;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dram_arbiter.sv
//------------------------------------------------------------------------------
// Module : tb_dram_arbiter
// Brief  : Self-checking bench for dram_arbiter with a small DRAM array model.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dram_arbiter;
    localparam int MB = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] dram_addr, dram_wdata, dram_rd;
    logic        dram_we;

    dram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
    dram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();

    dram_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m0         (m0_if),
        .m1         (m1_if),
        .dram_addr  (dram_addr),
        .dram_we    (dram_we),
        .dram_wdata (dram_wdata),
        .dram_rd    (dram_rd)
    );

    always #5 clk = ~clk;

    // DRAM array: combinational read, write commits on the clock edge.
    logic [31:0] mem [256];
    logic        mem_init_done = 1'b0;
    assign dram_rd = mem[dram_addr[9:2]];
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA5A50000 | 32'(i);
            mem[16]       <= 32'hDEADBEEF;
            mem_init_done <= 1'b1;
        end else if (dram_we) begin
            mem[dram_addr[9:2]] <= dram_wdata;
        end
    end

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic apply(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        m0_if.req = r0; m0_if.we = w0; m0_if.addr = a0; m0_if.wdata = d0;
        m1_if.req = r1; m1_if.we = w1; m1_if.addr = a1; m1_if.wdata = d1;
    endtask

    typedef struct {
        logic r0; logic w0; logic [31:0] a0; logic [31:0] d0;
        logic r1; logic w1; logic [31:0] a1; logic [31:0] d1;
        logic g0; logic g1; logic dwe; logic [31:0] daddr;
        logic rv0; logic rv1; logic [31:0] rd0; logic [31:0] rd1;
    } vec_t;

    vec_t tv [10];

    // Behavioural reference state for the random phase.
    int          own, last, taken;
    logic        req [2], we [2], acc_prev [2], pend_rv [2];
    logic [31:0] addr [2], wdata [2], exp_rd [2];
    logic [31:0] ref_mem [256];
    int          wait_c [2];

    initial begin
        // Single read by m1, m0 write, then handover read-back by m1 and idle.
        tv[0] = '{0,0,32'h0,32'h0,         1,0,32'h40,32'h0,  0,0,0,32'h0,   0,0,32'h0,32'h0};
        tv[1] = '{0,0,32'h0,32'h0,         1,0,32'h40,32'h0,  0,1,0,32'h40,  0,0,32'h0,32'h0};
        tv[2] = '{0,0,32'h0,32'h0,         0,0,32'h0,32'h0,   0,1,0,32'h0,   0,1,32'h0,32'hDEADBEEF};
        tv[3] = '{0,0,32'h0,32'h0,         0,0,32'h0,32'h0,   0,0,0,32'h0,   0,0,32'h0,32'hDEADBEEF};
        tv[4] = '{1,1,32'h100,32'h12345678, 0,0,32'h0,32'h0,  0,0,0,32'h0,   0,0,32'h0,32'hDEADBEEF};
        tv[5] = '{1,1,32'h100,32'h12345678, 0,0,32'h0,32'h0,  1,0,1,32'h100, 0,0,32'h0,32'hDEADBEEF};
        tv[6] = '{0,0,32'h0,32'h0,         1,0,32'h100,32'h0, 1,0,0,32'h0,   0,0,32'h0,32'hDEADBEEF};
        tv[7] = '{0,0,32'h0,32'h0,         1,0,32'h100,32'h0, 0,1,0,32'h100, 0,0,32'h0,32'hDEADBEEF};
        tv[8] = '{0,0,32'h0,32'h0,         0,0,32'h0,32'h0,   0,1,0,32'h0,   0,1,32'h0,32'h12345678};
        tv[9] = '{0,0,32'h0,32'h0,         0,0,32'h0,32'h0,   0,0,0,32'h0,   0,0,32'h0,32'h12345678};

        for (int i = 0; i < 256; i++) ref_mem[i] = 32'hA5A50000 | 32'(i);
        ref_mem[16] = 32'hDEADBEEF;
        ref_mem[64] = 32'h12345678;

        rst_n = 1'b0;
        apply(0,0,0,0, 0,0,0,0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            apply(tv[i].r0, tv[i].w0, tv[i].a0, tv[i].d0, tv[i].r1, tv[i].w1, tv[i].a1, tv[i].d1);
            @(negedge clk);
            chk($sformatf("v%0d_gnt0", i),   32'(m0_if.gnt),    32'(tv[i].g0));
            chk($sformatf("v%0d_gnt1", i),   32'(m1_if.gnt),    32'(tv[i].g1));
            chk($sformatf("v%0d_we", i),     32'(dram_we),      32'(tv[i].dwe));
            chk($sformatf("v%0d_addr", i),   dram_addr,         tv[i].daddr);
            chk($sformatf("v%0d_rvalid0", i), 32'(m0_if.rvalid), 32'(tv[i].rv0));
            chk($sformatf("v%0d_rvalid1", i), 32'(m1_if.rvalid), 32'(tv[i].rv1));
            chk($sformatf("v%0d_rdata0", i), m0_if.rdata,       tv[i].rd0);
            chk($sformatf("v%0d_rdata1", i), m1_if.rdata,       tv[i].rd1);
        end

        // Async reset in the middle of an m0 burst: read, then a write cut off by reset.
        @(posedge clk); #1;
        apply(1,0,32'h8,0, 0,0,0,0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        apply(1,1,32'h200,32'hBAD0BAD0, 0,0,0,0);
        #1;
        chk("rst_pre_we",     32'(dram_we),      32'd1);
        chk("rst_pre_rvalid", 32'(m0_if.rvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_gnt0",   32'(m0_if.gnt),    32'd0);
        chk("rst_rvalid", 32'(m0_if.rvalid), 32'd0);
        chk("rst_we",     32'(dram_we),      32'd0);
        chk("rst_rdata0", m0_if.rdata,       32'd0);
        apply(1,0,32'h0,0, 1,0,32'h0,0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_no_partial_write", mem[128], 32'hA5A50080);
        rst_n = 1'b1;

        // Tie after reset goes to m0, then strict 8/8 alternation while both hold req.
        for (int c = 0; c < 4 * MB; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("burst%0d_gnt0", c), 32'(m0_if.gnt), 32'(((c / MB) % 2) == 0));
            chk($sformatf("burst%0d_gnt1", c), 32'(m1_if.gnt), 32'(((c / MB) % 2) == 1));
        end

        // Lone requester keeps the port across counter wraps.
        @(posedge clk); #1;
        apply(0,0,0,0, 0,0,0,0);
        repeat (2) @(posedge clk);
        #1;
        apply(1,0,32'h4,0, 0,0,0,0);
        @(negedge clk);
        chk("solo_idle_gnt0", 32'(m0_if.gnt), 32'd0);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("solo%0d_gnt0", c), 32'(m0_if.gnt), 32'd1);
            chk($sformatf("solo%0d_gnt1", c), 32'(m1_if.gnt), 32'd0);
        end

        // Randomized traffic against the reference model.
        @(posedge clk); #1;
        apply(0,0,0,0, 0,0,0,0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        own = -1; last = 1; taken = 0;
        for (int x = 0; x < 2; x++) begin
            req[x] = 0; we[x] = 0; addr[x] = 0; wdata[x] = 0;
            acc_prev[x] = 0; pend_rv[x] = 0; exp_rd[x] = 0; wait_c[x] = 0;
        end

        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(posedge clk); #1;
            for (int x = 0; x < 2; x++) begin
                if (!(req[x] && !acc_prev[x])) begin
                    req[x]   = ($urandom_range(0, 99) < 55);
                    we[x]    = 1'($urandom_range(0, 1));
                    addr[x]  = 32'($urandom_range(0, 255)) << 2;
                    wdata[x] = $urandom;
                end
            end
            apply(req[0], we[0], addr[0], wdata[0], req[1], we[1], addr[1], wdata[1]);
            @(negedge clk);

            chk("rnd_gnt0",    32'(m0_if.gnt),    32'(own == 0));
            chk("rnd_gnt1",    32'(m1_if.gnt),    32'(own == 1));
            chk("rnd_addr",    dram_addr,  (own >= 0) ? addr[own]  : 32'h0);
            chk("rnd_wdata",   dram_wdata, (own >= 0) ? wdata[own] : 32'h0);
            chk("rnd_we",      32'(dram_we), 32'((own >= 0) && req[own] && we[own]));
            chk("rnd_rvalid0", 32'(m0_if.rvalid), 32'(pend_rv[0]));
            chk("rnd_rvalid1", 32'(m1_if.rvalid), 32'(pend_rv[1]));
            chk("rnd_rdata0",  m0_if.rdata, exp_rd[0]);
            chk("rnd_rdata1",  m1_if.rdata, exp_rd[1]);

            wait_c[0] = (req[0] && !m0_if.gnt) ? wait_c[0] + 1 : 0;
            wait_c[1] = (req[1] && !m1_if.gnt) ? wait_c[1] + 1 : 0;
            chk("rnd_wait0", 32'(wait_c[0] > MB + 1), 32'd0);
            chk("rnd_wait1", 32'(wait_c[1] > MB + 1), 32'd0);

            // Advance the model by one clock using the inputs just applied.
            acc_prev[0] = (own == 0) && req[0];
            acc_prev[1] = (own == 1) && req[1];
            pend_rv[0] = 0; pend_rv[1] = 0;
            if (own < 0) begin
                if (req[0] || req[1]) begin
                    own   = (req[0] && req[1]) ? 1 - last : (req[1] ? 1 : 0);
                    last  = own;
                    taken = 0;
                end
            end else begin
                if (req[own]) begin
                    taken++;
                    if (we[own]) ref_mem[addr[own][9:2]] = wdata[own];
                    else begin
                        pend_rv[own] = 1;
                        exp_rd[own]  = ref_mem[addr[own][9:2]];
                    end
                end
                if (req[1 - own] && (!req[own] || taken == MB)) begin
                    own   = 1 - own;
                    last  = own;
                    taken = 0;
                end else if (!req[own]) begin
                    own   = -1;
                    taken = 0;
                end else if (taken == MB) begin
                    taken = 0;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
